// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues fetches to a one-cycle-latency
// instruction memory and buffers returned words in a 2-entry FIFO for decode.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned N        = 32'd20
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        misalign_err,
    output logic        range_err
);
    localparam logic [31:0] LAST_IDX = 32'(N);

    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] inst0_q, inst0_d, pc0_q, pc0_d;
    logic [31:0] inst1_q, inst1_d, pc1_q, pc1_d;
    logic        dec_valid_q, dec_valid_d;
    logic        misalign_err_q, misalign_err_d;
    logic        range_err_q, range_err_d;
    logic        pop_s, in_range_s, issue_s;
    logic [2:0]  occ_s;

    // Issue decision: room must remain for the word already in flight.
    always_comb begin
        pop_s      = dec_valid_q & dec_ready;
        in_range_s = ({2'b00, pc_q[31:2]} <= LAST_IDX);
        occ_s      = {1'b0, count_q} + {2'b00, infl_v_q} - {2'b00, pop_s};
        issue_s    = !redirect_valid && in_range_s && (occ_s < 3'd2);
    end

    // Next-state for PC, in-flight tag, FIFO entries and sticky error flags.
    always_comb begin
        pc_d           = pc_q;
        infl_v_d       = 1'b0;
        infl_pc_d      = infl_pc_q;
        count_d        = count_q;
        inst0_d        = inst0_q;
        pc0_d          = pc0_q;
        inst1_d        = inst1_q;
        pc1_d          = pc1_q;
        misalign_err_d = misalign_err_q;
        if (!in_range_s) begin
            range_err_d = 1'b1;
        end else begin
            range_err_d = range_err_q;
        end
        if (redirect_valid) begin
            // Flush; any word returning this cycle belongs to the old stream.
            pc_d    = {redirect_pc[31:2], 2'b00};
            count_d = 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err_d = 1'b1;
            end else begin
                misalign_err_d = misalign_err_q;
            end
        end else begin
            if (issue_s) begin
                pc_d      = pc_q + 32'd4;
                infl_v_d  = 1'b1;
                infl_pc_d = pc_q;
            end else begin
                pc_d     = pc_q;
                infl_v_d = 1'b0;
            end
            // Entry 0 is always the head; entry 1 shifts down on pop.
            case ({infl_v_q, pop_s})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        inst0_d = imem_inst;
                        pc0_d   = infl_pc_q;
                    end else begin
                        inst1_d = imem_inst;
                        pc1_d   = infl_pc_q;
                    end
                end
                2'b01: begin
                    count_d = count_q - 2'd1;
                    inst0_d = inst1_q;
                    pc0_d   = pc1_q;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        inst0_d = imem_inst;
                        pc0_d   = infl_pc_q;
                    end else begin
                        inst0_d = inst1_q;
                        pc0_d   = pc1_q;
                        inst1_d = imem_inst;
                        pc1_d   = infl_pc_q;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        dec_valid_d = (count_d != 2'd0);
    end

    // State registers; reset overrides everything including a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            infl_v_q       <= 1'b0;
            infl_pc_q      <= 32'd0;
            count_q        <= 2'd0;
            inst0_q        <= 32'd0;
            pc0_q          <= 32'd0;
            inst1_q        <= 32'd0;
            pc1_q          <= 32'd0;
            dec_valid_q    <= 1'b0;
            misalign_err_q <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            infl_v_q       <= infl_v_d;
            infl_pc_q      <= infl_pc_d;
            count_q        <= count_d;
            inst0_q        <= inst0_d;
            pc0_q          <= pc0_d;
            inst1_q        <= inst1_d;
            pc1_q          <= pc1_d;
            dec_valid_q    <= dec_valid_d;
            misalign_err_q <= misalign_err_d;
            range_err_q    <= range_err_d;
        end
    end

    assign imem_pc      = pc_q;
    assign dec_valid    = dec_valid_q;
    assign dec_inst     = inst0_q;
    assign dec_pc       = pc0_q;
    assign misalign_err = misalign_err_q;
    assign range_err    = range_err_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch initiator for the RISC-V core: owns the program counter, drives fetch addresses into the instruction memory, and collects the returned words. Sits between the instruction memory and decode. Absorbs the memory's fixed one-cycle registered read latency with a 2-entry buffer, so decode back-pressure and branch redirects never lose or duplicate an instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Must be word-aligned.
- `N`, default 20: last valid word index of instruction memory. Valid PCs satisfy `pc>>2 <= N`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `imem_pc`  out  32: fetch address to instruction memory. Combinational from the internal PC register `pc_q`.
- `imem_inst`  in  32: memory read data. Word for `imem_pc` presented in cycle t arrives in cycle t+1.
- `redirect_valid`  in  1: branch/jump redirect request from execute.
- `redirect_pc`  in  32: redirect target.
- `dec_ready`  in  1: decode can accept.
- `dec_valid`  out  1: `dec_inst`/`dec_pc` hold a valid instruction.
- `dec_inst`  out  32: instruction word.
- `dec_pc`  out  32: PC of `dec_inst`.
- `misalign_err`  out  1: sticky; a redirect target had `[1:0] != 0`.
- `range_err`  out  1: sticky; fetch reached `pc_q>>2 > N`.

## Operation
- **State:**
  - `pc_q`.
  - In-flight tag: `infl_v`, `infl_pc`, set when a fetch is issued.
  - 2-entry FIFO of {inst, pc}, with count 0..2.
- **Issue:** fetch of `pc_q` is issued in a cycle when all of these hold:
  - `!redirect_valid`
  - `pc_q>>2 <= N`
  - `count + infl_v - pop < 2`, where `pop = dec_valid & dec_ready`.
- **On issue:** `pc_q <= pc_q + 4` (mod 2^32), `infl_v <= 1`, `infl_pc <= pc_q`.
- **No issue:** `pc_q` holds and `infl_v <= 0`. Memory re-reads the same address; that result is ignored.
- **Capture:** when `infl_v = 1`, {`imem_inst`, `infl_pc`} is pushed into the FIFO at the end of the cycle. The issue rule guarantees the FIFO never overflows.
- **Output:**
  - `dec_valid = (count != 0)`; `dec_inst`/`dec_pc` = FIFO head.
  - Transfer occurs when `dec_valid & dec_ready`; the head is popped. Push and pop may occur in the same cycle.
  - `dec_inst`/`dec_pc` are don't-care when `dec_valid = 0`.
- **Redirect** in cycle t (highest priority):
  - FIFO is flushed (count ← 0), `infl_v <= 0`, `pc_q <= {redirect_pc[31:2], 2'b00}`.
  - If `redirect_pc[1:0] != 0`, `misalign_err <= 1`.
  - A `dec_valid & dec_ready` transfer in cycle t still completes; squashing that instruction is decode's responsibility.
- **Range:**
  - If `pc_q>>2 > N`, no issue and `range_err <= 1`.
  - Already-buffered instructions still drain to decode.
  - A redirect to an in-range target resumes fetching. Error flags clear only on `rst`.
- **Reset:** takes priority over everything, including mid-stream with a full FIFO.
  - `pc_q = RESET_PC`, so `imem_pc = RESET_PC`.
  - count = 0, `infl_v = 0`, `dec_valid = 0`, `dec_inst = 0`, `dec_pc = 0`, `misalign_err = 0`, `range_err = 0`.

## Timing
- Cycle 0 is the first cycle with `rst = 0`. The memory's output in cycle 0 is its reset value 0 and is ignored.
  - Cycle 0: issue `RESET_PC`.
  - Cycle 1: word captured.
  - Cycle 2: `dec_valid = 1`, `dec_pc = RESET_PC`.
- Fetch-to-decode latency is 2 cycles.
- Steady-state throughput is 1 instruction/cycle with `dec_ready` held high (count = 1, `infl_v = 1`).
- **Stall:**
  - Cycle s is the first cycle with `dec_ready = 0`. No issue occurs in cycle s, and from cycle s+1 count = 2.
  - While stalled the outputs hold their values.
  - Cycle r is the first cycle with `dec_ready = 1` again. The head transfers in cycle r, issue resumes in r, and the stream continues in order with no bubble until the FIFO drains.
- **Redirect in cycle t:**
  - Cycles t+1 and t+2: `dec_valid = 0`.
  - Cycle t+1: `imem_pc` = target.
  - Cycle t+3: target instruction on `dec_*`.
  - Redirect penalty is 2 bubbles.
- **Back-to-back redirects:** the last one wins; each restarts the t+3 timeline.

## Test plan
- **Free run:** `RESET_PC = 0`, `tab[k] = 32'h1000_0000 + k`, `dec_ready = 1` → `dec_valid` rises in cycle 2; `dec_pc` = 0, 4, 8, … with `dec_inst = tab[pc>>2]`; one transfer per cycle, no gaps.
- **Stall:** `dec_ready = 0` in cycles 5–8 → `dec_*` stable during the stall, `imem_pc` frozen, count = 2; from cycle 9 the sequence resumes with no skipped or repeated PC.
- **Redirect:** `redirect_valid = 1`, `redirect_pc = 0x20` in cycle 6 → `dec_valid = 0` in cycles 7–8; cycle 9 shows `dec_pc = 0x20`, `dec_inst = tab[8]`; then 0x24, 0x28, ….
- **Misaligned redirect:** `redirect_pc = 0x22` → `misalign_err = 1` from the next cycle; stream restarts at `dec_pc = 0x20`.
- **Range end:** `N = 20`, `RESET_PC = 0x48` → PCs 0x48, 0x4C, 0x50 are delivered; then `dec_valid = 0` permanently, `range_err = 1`, `imem_pc` stuck at 0x54. A subsequent redirect to 0x0 resumes fetch at 0x0 with `range_err` still 1.
- **Reset mid-stream:** assert `rst` with count = 2 and `dec_ready = 0` → next cycle `dec_valid = 0`, `imem_pc = RESET_PC`, both error flags 0; after release the first `dec_pc = RESET_PC` arrives 2 cycles later.
